slave_read_arb: RTL and testbench
=================================

Name: slave_read_arb

Overview:
- Shares one `slave_device` read port between NREQ requesters.
- Grants one requester at a time (round-robin) and sequences a full packet read: header bytes 0 and 1, then PKT_LEN payload bytes.
- Re-aligns the slave's read latency and forwards each byte, tagged with the requester id, to a shared consumer bus.
- Sits between the requester fabric and `slave_device` (drives its `ram_rd_rq`/`rd_addr`, samples its `data_o`).

Parameters:
- NREQ, 4, number of requesters (2..8).
- PKT_LEN, 16, payload bytes per packet; a packet is PKT_LEN+2 bytes including the 2-byte header.
- ADDR_W, 16, width of `rd_addr`.
- RD_LAT, 2, cycles from `rd_addr` presented to matching byte valid on `sd_data`.
- ID_W, 2, width of `out_id`; must be >= clog2(NREQ).

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_l` input 1: asynchronous, active-high reset (1 = in reset).
- `req` input NREQ: per-requester packet request, level.
- `gnt` output NREQ: one-hot grant, held for the whole packet.
- `ram_rd_rq` output 1: read request to `slave_device`.
- `rd_addr` output ADDR_W: byte address to `slave_device`.
- `sd_data` input 8: `data_o` from `slave_device`.
- `out_valid` output 1: `out_data` is valid this cycle.
- `out_data` output 8: forwarded byte.
- `out_id` output ID_W: index of the granted requester.
- `out_sop` output 1: first byte of packet (header MSB).
- `out_eop` output 1: last payload byte.
- `busy` output 1: a packet is in flight (ISSUE or DRAIN).

Behaviour:
- Reset values:
  - `gnt`=0, `ram_rd_rq`=0, `rd_addr`=0.
  - `out_valid`/`out_sop`/`out_eop`=0, `out_data`=0, `out_id`=0, `busy`=0.
  - RR pointer=NREQ-1, so requester 0 wins first; state=IDLE; valid pipe cleared.
- Reset asserted mid-packet aborts immediately: all outputs return to reset values and no partial bytes are emitted after reset.
- FSM states: IDLE, ISSUE, DRAIN, GAP.
- IDLE:
  - If `req`≠0, select the winner by round-robin, searching upward from pointer+1 with wrap to 0.
  - Register a one-hot `gnt` and the winner's id, set pointer=winner, go to ISSUE.
  - If `req`=0, stay in IDLE.
- ISSUE:
  - `ram_rd_rq`=1 and `rd_addr` = 0,1,…,PKT_LEN+1, one address per cycle.
  - After the cycle presenting PKT_LEN+1, go to DRAIN.
  - ISSUE lasts exactly PKT_LEN+2 cycles.
- DRAIN:
  - `ram_rd_rq`=0 and `rd_addr` held at 0.
  - Stay RD_LAT cycles until the last byte has been emitted, then go to GAP.
- GAP:
  - 1 idle cycle: `ram_rd_rq`=0, `gnt`=0.
  - Then go to IDLE; the next arbitration happens in IDLE.
  - The gap guarantees the slave read-enable deasserts between packets.
- `busy`=1 in ISSUE and DRAIN.
- Valid pipe:
  - A shift register of depth RD_LAT carries {issued, is_first, is_last} per address.
  - At the pipe output: `out_valid`=issued, `out_data`=`sd_data`, `out_sop`=is_first (address 0), `out_eop`=is_last (address PKT_LEN+1).
  - `out_id` is held stable from grant through eop.
- Latency:
  - First `out_valid` comes RD_LAT cycles after the first ISSUE cycle.
  - `out_valid` is asserted for exactly PKT_LEN+2 consecutive cycles per packet.
- Per-packet cadence: PKT_LEN+2+RD_LAT+1 cycles from grant to the next IDLE.
- No backpressure: the consumer must accept every `out_valid` byte.
- `req` handling:
  - `req` drop while granted does not abort; the packet completes.
  - `req` still high after GAP re-arbitrates normally, so the same requester wins again only if no other requester is active.
- Simultaneous requests: exactly one grant; the others wait; no requester waits more than NREQ-1 packets.
- `rd_addr` counter is ADDR_W wide with zero-extended compare; PKT_LEN+1 must be < 2^ADDR_W, otherwise elaboration error.

Optional Feature:
- Macro: `SLAVE_READ_ARB_FIXED_PRIO_EN`.
- Defined:
  - Fixed priority; the lowest-index active `req` always wins.
  - The RR pointer is removed.
  - Starvation of high indices is permitted.
- Undefined (default): round-robin as in Behaviour.
- All other timing is identical in both builds.

Test Plan:
- Reset then `req`=4'b0001 held, PKT_LEN=16, RD_LAT=2:
  - `gnt`=0001 the cycle after `req` is sampled.
  - `rd_addr` 0..17 on consecutive cycles.
  - `out_valid` for 18 cycles starting 2 cycles after `rd_addr`=0, `out_sop` on the first, `out_eop` on the 18th, `out_id`=0.
  - 1-cycle GAP, then re-grant to 0.
- `req`=4'b1111 held for 8 packets:
  - Grant order 0,1,2,3,0,1,2,3.
  - `gnt` always one-hot; no `out_valid` overlap between packets.
  - With `SLAVE_READ_ARB_FIXED_PRIO_EN`: grant is always 0.
- Slave model returns `sd_data`=address-tagged pattern (header 0x00,0x01 then payload 0x10+i):
  - `out_data` matches the sequence byte-for-byte in order.
  - No duplicated or dropped bytes.
- Granted requester drops `req` on the 3rd ISSUE cycle:
  - The packet still emits all 18 bytes with eop.
  - Next arbitration excludes that requester.
- Assert `rst_l`=1 on the 5th ISSUE cycle for 2 cycles:
  - All outputs go to 0 asynchronously.
  - After release with `req`=4'b0010, a fresh packet starts at `rd_addr`=0 with sop, granted to 1.
- `req`=4'b0100 arrives one cycle into GAP of a packet for requester 0 (`req` 0 dropped):
  - Requester 2 is granted in the following IDLE.
  - Exactly one GAP cycle with `ram_rd_rq`=0 between packets.

Source files
------------

// File: rtl/slave_read_arb.sv
// Purpose : round-robin sharing of one slave_device read port; each grant reads a full packet
//           (2 header bytes + PKT_LEN payload bytes) and forwards it id-tagged to a shared consumer.
// Latency : first out_valid RD_LAT cycles after the first ISSUE cycle; grant-to-next-IDLE is PKT_LEN+2+RD_LAT+1.
// Backpr. : none -- the consumer must take every out_valid byte; requesters wait on gnt.
// Option  : define SLAVE_READ_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no RR pointer).
module slave_read_arb #(
    parameter int NREQ    = 4,
    parameter int PKT_LEN = 16,
    parameter int ADDR_W  = 16,
    parameter int RD_LAT  = 2,
    parameter int ID_W    = 2
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   gnt,
    output logic              ram_rd_rq,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        sd_data,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic [ID_W-1:0]   out_id,
    output logic              out_sop,
    output logic              out_eop,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(PKT_LEN + 1);
    localparam logic [DW-1:0]     DRAIN_LAST = DW'(RD_LAT - 1);

    // Parameter sanity: the address counter must reach PKT_LEN+1 without wrapping,
    // the id field must hold every requester index, and the pipe needs at least one stage.
    generate
        if ((longint'(PKT_LEN) + 1) >= (longint'(1) << ADDR_W)) begin : g_bad_addr_w
            $error("slave_read_arb: PKT_LEN+1 does not fit in ADDR_W bits");
        end
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $error("slave_read_arb: NREQ must be in 2..8");
        end
        if (ID_W < PW) begin : g_bad_id_w
            $error("slave_read_arb: ID_W too narrow for NREQ");
        end
        if (RD_LAT < 1) begin : g_bad_rd_lat
            $error("slave_read_arb: RD_LAT must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] cnt_q;        // address being presented while in ISSUE
    logic [DW-1:0]     drain_cnt_q;  // cycles spent in DRAIN
    logic [NREQ-1:0]   gnt_q;
    logic [PW-1:0]     id_q;
    logic [PW-1:0]     win;          // arbitration winner this cycle
    logic [NREQ-1:0]   win_oh;

    // Valid pipe: one {issued, first, last} triple per presented address.
    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_first;
    logic [RD_LAT-1:0] pipe_last;

    logic issuing;
    logic issue_first;
    logic issue_last;

    assign issuing     = (state_q == ISSUE);
    assign issue_first = issuing && (cnt_q == '0);
    assign issue_last  = issuing && (cnt_q == LAST_ADDR);

`ifdef SLAVE_READ_ARB_FIXED_PRIO_EN
    // Fixed priority: scan from the top so the lowest active index is left as winner.
    always_comb begin
        win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win = PW'(i);
            end
        end
    end
`else
    logic [PW-1:0] ptr_q;  // last winner; search begins just above it
    logic          found;

    // Round-robin: first active requester strictly after the pointer, wrapping to 0.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && req[(int'(ptr_q) + i) % NREQ]) begin
                win   = PW'((int'(ptr_q) + i) % NREQ);
                found = 1'b1;
            end
        end
    end

    // Pointer moves to the winner at each grant.
    always_ff @(posedge clk or posedge rst_l) begin
        if (rst_l) begin
            ptr_q <= PW'(NREQ - 1);
        end else if (state_q == IDLE && (|req)) begin
            ptr_q <= win;
        end
    end
`endif

    // One-hot decode of the winner for the grant register.
    always_comb begin
        win_oh      = '0;
        win_oh[win] = 1'b1;
    end

    // Next-state logic for the packet sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst_l) begin
        if (rst_l) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant, id and counters: gnt/id latch at arbitration, gnt drops on entry to GAP.
    always_ff @(posedge clk or posedge rst_l) begin
        if (rst_l) begin
            gnt_q       <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            drain_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q       <= '0;
                    drain_cnt_q <= '0;
                    if (|req) begin
                        gnt_q <= win_oh;
                        id_q  <= win;
                    end
                end
                ISSUE: begin
                    drain_cnt_q <= '0;
                    if (cnt_q == LAST_ADDR) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        drain_cnt_q <= '0;
                        gnt_q       <= '0;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                default: begin
                    gnt_q       <= '0;
                    cnt_q       <= '0;
                    drain_cnt_q <= '0;
                end
            endcase
        end
    end

    // Valid pipe: delays the issue markers by RD_LAT to line up with sd_data.
    always_ff @(posedge clk or posedge rst_l) begin
        if (rst_l) begin
            pipe_vld   <= '0;
            pipe_first <= '0;
            pipe_last  <= '0;
        end else begin
            pipe_vld[0]   <= issuing;
            pipe_first[0] <= issue_first;
            pipe_last[0]  <= issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]   <= pipe_vld[i-1];
                pipe_first[i] <= pipe_first[i-1];
                pipe_last[i]  <= pipe_last[i-1];
            end
        end
    end

    assign gnt       = gnt_q;
    assign ram_rd_rq = issuing;
    assign rd_addr   = issuing ? cnt_q : '0;
    assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
    assign out_valid = pipe_vld[RD_LAT-1];
    assign out_sop   = pipe_vld[RD_LAT-1] && pipe_first[RD_LAT-1];
    assign out_eop   = pipe_vld[RD_LAT-1] && pipe_last[RD_LAT-1];
    // Data is masked outside valid so the bus idles at zero (including during reset).
    assign out_data  = pipe_vld[RD_LAT-1] ? sd_data : 8'h00;
    assign out_id    = ID_W'(id_q);

endmodule

// File: tb/tb_slave_read_arb.sv
// Bench for slave_read_arb: directed packets with a queue scoreboard and an independent output monitor.
// Default parameters (NREQ=4, PKT_LEN=16, RD_LAT=2).
module tb_slave_read_arb;

    logic       clk;
    logic       rst_l;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       ram_rd_rq;
    logic [15:0] rd_addr;
    logic [7:0] sd_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_id;
    logic       out_sop;
    logic       out_eop;
    logic       busy;

    int vectors = 0;
    int fails   = 0;
    logic [11:0] sbq[$];   // {id[1:0], sop, eop, data[7:0]}
    logic [7:0]  sd_p1;

    slave_read_arb dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .req       (req),
        .gnt       (gnt),
        .ram_rd_rq (ram_rd_rq),
        .rd_addr   (rd_addr),
        .sd_data   (sd_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: address-tagged bytes, two-cycle read latency; 0xEE when not read.
    function automatic logic [7:0] pat(input logic [15:0] a);
        if (a < 16'd2) return a[7:0];
        return 8'h10 + 8'(a - 16'd2);
    endfunction

    always @(posedge clk) begin
        sd_p1   <= ram_rd_rq ? pat(rd_addr) : 8'hEE;
        sd_data <= sd_p1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected byte stream of one packet (or its first n bytes).
    task automatic push_pkt(input int id, input int n);
        logic [7:0] d;
        for (int k = 0; k < n; k++) begin
            d = (k < 2) ? 8'(k) : 8'(8'h10 + k - 2);
            sbq.push_back({2'(id), 1'(k == 0), 1'(k == 17), d});
        end
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_gnt"},       32'(gnt), 0);
        chk({tag, "_ram_rd_rq"}, 32'(ram_rd_rq), 0);
        chk({tag, "_rd_addr"},   32'(rd_addr), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_data"},  32'(out_data), 0);
        chk({tag, "_out_id"},    32'(out_id), 0);
        chk({tag, "_out_sop"},   32'(out_sop), 0);
        chk({tag, "_out_eop"},   32'(out_eop), 0);
        chk({tag, "_busy"},      32'(busy), 0);
    endtask

    // Waits for a grant, then checks one whole packet cycle by cycle; returns in the GAP cycle.
    // waited = cycles from call to first ISSUE cycle; req is replaced by new_req at ISSUE cycle drop_at.
    task automatic run_pkt(input int exp_id, input int drop_at, input logic [3:0] new_req,
                           output int waited);
        waited = 0;
        while (gnt == 4'b0 && waited < 40) begin
            tick();
            waited++;
        end
        chk("grant_seen", 32'(gnt != 4'b0), 1);
        if (gnt == 4'b0) return;
        chk("gnt", 32'(gnt), 32'(1) << exp_id);
        chk("out_id_at_grant", 32'(out_id), 32'(exp_id));
        push_pkt(exp_id, 18);
        for (int i = 0; i < 18; i++) begin
            chk("rd_addr", 32'(rd_addr), 32'(i));
            chk("ram_rd_rq", 32'(ram_rd_rq), 1);
            if (i < 2) chk("early_valid", 32'(out_valid), 0);
            if (i == 2) chk("first_valid_sop", 32'({out_valid, out_sop}), 3);
            if (i == drop_at) req = new_req;
            tick();
        end
        chk("drain_rq_addr", 32'({ram_rd_rq, rd_addr}), 0);
        chk("drain_busy_gnt", 32'({busy, gnt}), 32'({1'b1, 4'(4'b0001 << exp_id)}));
        tick();
        chk("last_valid_eop", 32'({out_valid, out_eop, busy}), 7);
        tick();
        chk("gap_state", 32'({gnt, ram_rd_rq, busy, out_valid}), 0);
    endtask

    // Monitor: compares every presented byte against the scoreboard head; checks gnt one-hot.
    always @(negedge clk) begin
        chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
        if (out_valid) begin
            if (sbq.size() == 0) begin
                vectors++;
                fails++;
                $display("FAIL unexpected_byte: got id=%0d data=%0h, expected no byte", out_id, out_data);
            end else begin
                chk("out_byte", 32'({out_id, out_sop, out_eop, out_data}), 32'(sbq.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int exp_id;
        int waited;
        rst_l = 1'b1;
        req   = 4'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset");
        rst_l = 1'b0;
        tick();

        // Single requester held: two back-to-back packets to 0, req dropped in the second.
        req = 4'b0001;
        run_pkt(0, -1, 4'b0, w);
        run_pkt(0, 0, 4'b0000, w);
        chk("b2b_gap_0", 32'(w), 2);

        // All requesting: rotation from pointer 0; requester 0 drops on 3rd ISSUE cycle of packet 8.
        req = 4'b1111;
        for (int p = 0; p < 8; p++) begin
`ifdef SLAVE_READ_ARB_FIXED_PRIO_EN
            exp_id = 0;
`else
            exp_id = (p + 1) % 4;
`endif
            run_pkt(exp_id, (p == 7) ? 2 : -1, 4'b1110, w);
            if (p > 0) chk("b2b_gap_rr", 32'(w), 2);
        end
        run_pkt(1, 0, 4'b0000, w);
        chk("after_drop_gap", 32'(w), 2);

        // Reset on the 5th ISSUE cycle of a packet to requester 2.
        tick();
        req = 4'b0100;
        waited = 0;
        while (gnt == 4'b0 && waited < 40) begin
            tick();
            waited++;
        end
        chk("rst_pkt_gnt", 32'(gnt), 32'h4);
        push_pkt(2, 2);
        repeat (4) tick();
        chk("rst_pkt_addr4", 32'(rd_addr), 4);
        rst_l = 1'b1;
        req   = 4'b0010;
        #1;
        check_reset_outs("midrst");
        tick();
        tick();
        rst_l = 1'b0;
        run_pkt(1, 0, 4'b0000, w);

        // Requester 2 arrives during the GAP of a packet to 0.
        req = 4'b0001;
        run_pkt(0, 0, 4'b0000, w);
        req = 4'b0100;
        run_pkt(2, 0, 4'b0000, w);
        chk("gap_arrival_gap", 32'(w), 2);

        repeat (5) tick();
        chk("sb_empty", 32'(sbq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
